// File: rtl/datamem_pkg.sv
// datamem_pkg: shared encodings and latency limits for the datamem_param block.
package datamem_pkg;
  typedef enum logic [1:0] {SZ_BYTE = 2'b00, SZ_HALF = 2'b01, SZ_WORD = 2'b10, SZ_RSVD = 2'b11} size_e;
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;
  localparam int LAT_MIN = 1;
  localparam int LAT_MAX = 8;
  localparam int LAT_CNT_W = $clog2(LAT_MAX);
endpackage

// File: rtl/datamem_load_fmt.sv
// datamem_load_fmt: moves the addressed load lanes to bit 0 and sign/zero-extends them.
module datamem_load_fmt
  import datamem_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0]          word_i,
  input  logic [$clog2(DATA_W/8)-1:0] off_i,
  input  size_e                      size_i,
  input  logic                       uns_i,
  output logic [DATA_W-1:0]          data_o
);
  logic [DATA_W-1:0] sh;
  logic sb;
  assign sh = word_i >> {off_i, 3'b000};
  assign sb = ~uns_i & (size_i == SZ_BYTE ? sh[7] : sh[15]);
  assign data_o = size_i == SZ_BYTE ? {{(DATA_W-8){sb}}, sh[7:0]}
                : size_i == SZ_HALF ? {{(DATA_W-16){sb}}, sh[15:0]} : sh;
endmodule

// File: rtl/datamem_param.sv
// datamem_param: byte-addressable data memory with fixed response latency.
// Define DMEM_ALIGN_CHECK_EN to reject misaligned and reserved-size accesses with rsp_err.
module datamem_param
  import datamem_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_write_i,
  input  logic [31:0]       req_addr_i,
  input  logic [1:0]        req_size_i,
  input  logic              req_unsigned_i,
  input  logic [DATA_W-1:0] req_wdata_i,
  output logic              rsp_valid_o,
  output logic [DATA_W-1:0] rsp_rdata_o,
  output logic              rsp_err_o
);
  localparam int OFF = $clog2(DATA_W/8);
  localparam int IDX_W = $clog2(DEPTH);
  typedef logic [DATA_W-1:0] word_t;
  word_t mem_q [DEPTH] = '{default: '0};
  state_e state_q, state_d;
  logic [LAT_CNT_W-1:0] cnt_q, cnt_d;
  word_t hold_data_q, hold_data_d, rdata_q, rdata_d;
  logic hold_err_q, hold_err_d, err_q, err_d;
  logic acc, bad, unused_addr;
  size_e sz;
  logic [OFF-1:0] off;
  logic [OFF+2:0] sh;
  logic [IDX_W-1:0] idx;
  word_t rword, fmt_data, wmask, res;
  assign unused_addr = ^req_addr_i[31:OFF+IDX_W];
  assign idx = req_addr_i[OFF +: IDX_W];
  assign sz = size_e'(req_size_i) == SZ_RSVD ? SZ_WORD : size_e'(req_size_i);
  assign off = sz == SZ_WORD ? '0 : sz == SZ_HALF ? {req_addr_i[OFF-1:1], 1'b0} : req_addr_i[OFF-1:0];
  assign sh = {off, 3'b000};
`ifdef DMEM_ALIGN_CHECK_EN
  assign bad = size_e'(req_size_i) == SZ_RSVD || req_addr_i[OFF-1:0] != off;
`else
  assign bad = 1'b0;
`endif
  assign acc = req_valid_i & req_ready_o & ~rst;
  assign rword = mem_q[idx];
  assign wmask = sz == SZ_BYTE ? word_t'(8'hFF) << sh : sz == SZ_HALF ? word_t'(16'hFFFF) << sh : '1;
  assign res = (bad || req_write_i) ? '0 : fmt_data;
  datamem_load_fmt #(.DATA_W(DATA_W)) u_fmt (
    .word_i (rword),
    .off_i  (off),
    .size_i (sz),
    .uns_i  (req_unsigned_i),
    .data_o (fmt_data)
  );
  always_ff @(posedge clk)
    if (acc && req_write_i && !bad) mem_q[idx] <= (rword & ~wmask) | ((req_wdata_i << sh) & wmask);
  always_ff @(posedge clk)
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      hold_data_q <= '0;
      hold_err_q  <= 1'b0;
      rdata_q     <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      hold_data_q <= hold_data_d;
      hold_err_q  <= hold_err_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
    end
  // Loads are formatted at acceptance so the response only has to be delayed, not re-read.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    hold_data_d = hold_data_q;
    hold_err_d  = hold_err_q;
    rdata_d     = rdata_q;
    err_d       = err_q;
    if (state_q == WAIT) begin
      if (cnt_q == '0) begin
        state_d = RESP;
        rdata_d = hold_data_q;
        err_d   = hold_err_q;
      end else cnt_d = cnt_q - 1'b1;
    end else if (acc) begin
      if (LATENCY == 1) begin
        state_d = RESP;
        rdata_d = res;
        err_d   = bad;
      end else begin
        state_d     = WAIT;
        cnt_d       = LAT_CNT_W'(LATENCY - 2);
        hold_data_d = res;
        hold_err_d  = bad;
      end
    end else state_d = IDLE;
  end
  always_comb begin
    req_ready_o = state_q != WAIT;
    rsp_valid_o = state_q == RESP;
    rsp_rdata_o = rdata_q;
    rsp_err_o   = err_q;
  end
endmodule

// File: tb/tb_datamem_param.sv
// tb_datamem_param: random and directed checks of three datamem_param instances (LATENCY 1, 3, 4).
module tb_datamem_param;
  localparam int LATS [3] = '{1, 3, 4};
  logic clk = 1'b0;
  logic [2:0] rst_v, req_valid, req_write, req_uns, req_ready, rsp_valid, rsp_err;
  logic [2:0][31:0] req_addr, req_wdata, rsp_rdata;
  logic [2:0][1:0] req_size;
  logic [7:0] mb [3][4096];
  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] pd0;
  bit pe0, have0;
  always #5 clk = ~clk;
  for (genvar g = 0; g < 3; g++) begin : g_dut
    datamem_param #(.DATA_W(32), .DEPTH(1024), .LATENCY(LATS[g])) u_dut (
      .clk            (clk),
      .rst            (rst_v[g]),
      .req_valid_i    (req_valid[g]),
      .req_ready_o    (req_ready[g]),
      .req_write_i    (req_write[g]),
      .req_addr_i     (req_addr[g]),
      .req_size_i     (req_size[g]),
      .req_unsigned_i (req_uns[g]),
      .req_wdata_i    (req_wdata[g]),
      .rsp_valid_o    (rsp_valid[g]),
      .rsp_rdata_o    (rsp_rdata[g]),
      .rsp_err_o      (rsp_err[g])
    );
  end
  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %08h expected %08h at %0t", tag, got, exp, $time);
    end
  endtask
  // Byte-array reference: little-endian, address modulo 4 KiB, size in bytes.
  function automatic void model(int k, bit w, logic [31:0] a, logic [1:0] s, bit u, logic [31:0] d,
                                output logic [31:0] rd, output bit er);
    int n, base;
    logic [31:0] v;
    n = s == 2'd0 ? 1 : s == 2'd1 ? 2 : 4;
    v = '0;
    rd = '0;
    er = 1'b0;
`ifdef DMEM_ALIGN_CHECK_EN
    er = (s == 2'd3) || (int'(a[1:0]) % n != 0);
`endif
    if (er) return;
    base = int'(a[11:0]) & ~(n - 1);
    for (int i = 0; i < n; i++)
      if (w) mb[k][base+i] = d[8*i +: 8];
      else v |= 32'(mb[k][base+i]) << (8 * i);
    if (!w) rd = (!u && n < 4 && v[8*n-1]) ? v | ~((32'd1 << (8 * n)) - 1) : v;
  endfunction
  task automatic drive(int k, bit w, logic [31:0] a, logic [1:0] s, bit u, logic [31:0] d);
    req_valid[k] = 1'b1;
    req_write[k] = w;
    req_addr[k]  = a;
    req_size[k]  = s;
    req_uns[k]   = u;
    req_wdata[k] = d;
  endtask
  task automatic idle(int k);
    req_valid[k] = 1'b0;
    req_write[k] = 1'($urandom);
    req_addr[k]  = $urandom;
    req_size[k]  = 2'($urandom);
    req_uns[k]   = 1'($urandom);
    req_wdata[k] = $urandom;
  endtask
  task automatic rnd(output bit w, output logic [31:0] a, output logic [1:0] s, output bit u, output logic [31:0] d);
    w = 1'($urandom_range(0, 1));
    a = 32'($urandom_range(0, 63)) | (32'($urandom_range(0, 3)) << 12);
    s = 2'($urandom_range(0, 3));
    u = 1'($urandom_range(0, 1));
    d = $urandom;
  endtask
  task automatic step0(bit w, logic [31:0] a, logic [1:0] s, bit u, logic [31:0] d);
    if (have0) begin
      check("s_valid", 32'(rsp_valid[0]), 1);
      check("s_rdata", rsp_rdata[0], pd0);
      check("s_err", 32'(rsp_err[0]), 32'(pe0));
    end
    check("s_ready", 32'(req_ready[0]), 1);
    model(0, w, a, s, u, d, pd0, pe0);
    drive(0, w, a, s, u, d);
    have0 = 1'b1;
    @(negedge clk);
  endtask
  task automatic flush0();
    check("f_valid", 32'(rsp_valid[0]), 1);
    check("f_rdata", rsp_rdata[0], pd0);
    idle(0);
    have0 = 1'b0;
    @(negedge clk);
    check("f_drop", 32'(rsp_valid[0]), 0);
    check("f_hold", rsp_rdata[0], pd0);
    check("f_herr", 32'(rsp_err[0]), 32'(pe0));
  endtask
  task automatic txn(int k, bit w, logic [31:0] a, logic [1:0] s, bit u, logic [31:0] d, bit tail);
    logic [31:0] ed;
    bit ee;
    model(k, w, a, s, u, d, ed, ee);
    check("t_ready_pre", 32'(req_ready[k]), 1);
    drive(k, w, a, s, u, d);
    @(negedge clk);
    idle(k);
    for (int j = 1; j < LATS[k]; j++) begin
      check("t_wait_ready", 32'(req_ready[k]), 0);
      check("t_wait_valid", 32'(rsp_valid[k]), 0);
      @(negedge clk);
    end
    check("t_valid", 32'(rsp_valid[k]), 1);
    check("t_rdata", rsp_rdata[k], ed);
    check("t_err", 32'(rsp_err[k]), 32'(ee));
    check("t_ready_rsp", 32'(req_ready[k]), 1);
    if (tail) begin
      @(negedge clk);
      check("t_drop", 32'(rsp_valid[k]), 0);
      check("t_hold", rsp_rdata[k], ed);
      check("t_herr", 32'(rsp_err[k]), 32'(ee));
    end
  endtask
  initial begin
    bit w, u;
    logic [31:0] a, d;
    logic [1:0] s;
    for (int k = 0; k < 3; k++) begin
      idle(k);
      for (int i = 0; i < 4096; i++) mb[k][i] = '0;
    end
    have0 = 1'b0;
    rst_v = '1;
    repeat (2) @(negedge clk);
    rst_v = '0;
    for (int k = 0; k < 3; k++) begin
      check("rst_ready", 32'(req_ready[k]), 1);
      check("rst_valid", 32'(rsp_valid[k]), 0);
      check("rst_rdata", rsp_rdata[k], 0);
      check("rst_err", 32'(rsp_err[k]), 0);
    end
    // LATENCY 1: back-to-back store/load and sub-word extension
    step0(1, 32'h10, 2, 0, 32'hDEADBEEF);
    step0(0, 32'h10, 2, 0, 32'h0);
    step0(1, 32'h11, 0, 0, 32'h80);
    step0(0, 32'h11, 0, 0, 32'h0);
    step0(0, 32'h11, 0, 1, 32'h0);
    step0(0, 32'h10, 2, 0, 32'h0);
    flush0();
    check("word_after_byte", rsp_rdata[0], 32'hDEAD80EF);
    for (int i = 0; i < 300; i++) begin
      rnd(w, a, s, u, d);
      step0(w, a, s, u, d);
    end
    flush0();
    // LATENCY 3: half store at odd address, then random, then reset mid-flight
    txn(1, 1, 32'h21, 1, 0, 32'h1234A5B6, 1);
    txn(1, 0, 32'h20, 2, 0, 32'h0, 1);
`ifdef DMEM_ALIGN_CHECK_EN
    check("half_odd_word", rsp_rdata[1], 32'h0);
`else
    check("half_odd_word", rsp_rdata[1], 32'h0000A5B6);
`endif
    for (int i = 0; i < 40; i++) begin
      rnd(w, a, s, u, d);
      txn(1, w, a, s, u, d, 1'($urandom_range(0, 1)));
    end
    check("r_ready", 32'(req_ready[1]), 1);
    drive(1, 0, 32'h10, 2, 0, 32'h0);
    @(negedge clk);
    idle(1);
    rst_v[1] = 1'b1;
    @(negedge clk);
    rst_v[1] = 1'b0;
    check("r_ready_after", 32'(req_ready[1]), 1);
    check("r_rdata_clr", rsp_rdata[1], 0);
    check("r_err_clr", 32'(rsp_err[1]), 0);
    for (int i = 0; i < 5; i++) begin
      check("r_no_rsp", 32'(rsp_valid[1]), 0);
      @(negedge clk);
    end
    // LATENCY 4: accept legal in the response cycle, then address wrap
    txn(2, 0, 32'h200, 2, 0, 32'h0, 0);
    txn(2, 1, 32'h1000, 2, 0, 32'h12345678, 1);
    txn(2, 0, 32'h0, 2, 0, 32'h0, 1);
    check("wrap_word", rsp_rdata[2], 32'h12345678);
    for (int i = 0; i < 40; i++) begin
      rnd(w, a, s, u, d);
      txn(2, w, a, s, u, d, 1'($urandom_range(0, 1)));
    end
    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
